// File: rtl/digit_scan_mux.sv
// Time-multiplexed multi-digit display scanner: tear-free frame latch, leading-zero blanking, PWM dimming.
// Optional per-digit blinking is compiled in with `define DIGIT_BLINK_EN.
module digit_scan_mux #(
    parameter int DIGITS   = 8,
    parameter int DIV      = 1000,
    parameter int BRIGHT_W = 4
`ifdef DIGIT_BLINK_EN
    , parameter int BLINK_FRAMES = 50
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   digits_in,
    input  logic [DIGITS-1:0]     dp_in,
`ifdef DIGIT_BLINK_EN
    input  logic [DIGITS-1:0]     blink_mask,
`endif
    input  logic                  lz_blank,
    input  logic [BRIGHT_W-1:0]   brightness,
    output logic [3:0]            digit_val,
    output logic [DIGITS-1:0]     digit_sel,
    output logic                  dp_out,
    output logic                  frame_start
);
    localparam int IDX_W = $clog2(DIGITS);
    localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [PRE_W-1:0]             pre_q, pre_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    logic [BRIGHT_W-1:0]          pwm_q;
    logic                         load_q;
    logic [DIGITS-1:0][3:0]       sh_q, sh_d;
    logic [DIGITS-1:0]            shdp_q, shdp_d;
    logic [3:0]                   val_q, val_d;
    logic [DIGITS-1:0]            sel_q, sel_d;
    logic                         dp_q, dp_d;
    logic                         fs_q, fs_d;
    logic                         tick, frame_edge, on, lead, blank;
    logic [DIGITS-1:0]            lz_vec, blank_vec;

`ifdef DIGIT_BLINK_EN
    localparam int BFC_W = $clog2(BLINK_FRAMES + 1);
    logic [BFC_W-1:0]             bfc_q, bfc_d;
    logic                         phase_q, phase_d;
    logic [DIGITS-1:0]            bm_q, bm_d;
`endif

    always_comb begin
        tick       = (pre_q == PRE_W'(DIV - 1));
        frame_edge = load_q | (tick & (idx_q == IDX_W'(DIGITS - 1)));
        // The load edge restarts the slot so slot 0 after reset lasts a full DIV cycles.
        pre_d      = (load_q | tick) ? '0 : pre_q + 1'b1;
        idx_d      = idx_q;
        if (load_q || (tick && idx_q == IDX_W'(DIGITS - 1)))
            idx_d = '0;
        else if (tick)
            idx_d = idx_q + 1'b1;
        sh_d   = frame_edge ? digits_in : sh_q;
        shdp_d = frame_edge ? dp_in : shdp_q;

        lz_vec = '0;
        lead   = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            lead      = lead & (sh_d[k] == 4'h0) & ~shdp_d[k];
            lz_vec[k] = lead;
        end
        blank_vec = lz_blank ? lz_vec : '0;

`ifdef DIGIT_BLINK_EN
        bm_d    = frame_edge ? blink_mask : bm_q;
        bfc_d   = bfc_q;
        phase_d = phase_q;
        // bfc counts frames already started in the current phase.
        if (frame_edge) begin
            if (bfc_q == BFC_W'(BLINK_FRAMES)) begin
                bfc_d   = BFC_W'(1);
                phase_d = ~phase_q;
            end else begin
                bfc_d = bfc_q + 1'b1;
            end
        end
        if (phase_d)
            blank_vec = blank_vec | bm_d;
`endif

        blank = blank_vec[idx_d];
        on    = (&brightness) | (pwm_q < brightness);
        val_d = blank ? 4'hF : sh_d[idx_d];
        dp_d  = ~blank & shdp_d[idx_d];
        sel_d = '0;
        if (on && !blank)
            sel_d[idx_d] = 1'b1;
        fs_d  = frame_edge;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q  <= '0;
            idx_q  <= '0;
            pwm_q  <= '0;
            load_q <= 1'b1;
            sh_q   <= '0;
            shdp_q <= '0;
            val_q  <= '0;
            sel_q  <= '0;
            dp_q   <= 1'b0;
            fs_q   <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            idx_q  <= idx_d;
            pwm_q  <= pwm_q + 1'b1;
            load_q <= 1'b0;
            sh_q   <= sh_d;
            shdp_q <= shdp_d;
            val_q  <= val_d;
            sel_q  <= sel_d;
            dp_q   <= dp_d;
            fs_q   <= fs_d;
        end
    end

`ifdef DIGIT_BLINK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            bfc_q   <= '0;
            phase_q <= 1'b0;
            bm_q    <= '0;
        end else begin
            bfc_q   <= bfc_d;
            phase_q <= phase_d;
            bm_q    <= bm_d;
        end
    end
`endif

    assign digit_val   = val_q;
    assign digit_sel   = sel_q;
    assign dp_out      = dp_q;
    assign frame_start = fs_q;
endmodule

// File: tb/tb_digit_scan_mux.sv
// Randomised and directed bench for digit_scan_mux against a cycle-count based reference model.
module tb_digit_scan_mux;
    localparam int D = 4, V = 3, BW = 2, FRAME = D * V, BF = 2;

    logic          clk = 0;
    logic          rst = 1;
    logic [15:0]   digits_in = 16'h0;
    logic [3:0]    dp_in = 4'h0;
    logic [3:0]    blink_mask = 4'h0;
    logic          lz_blank = 0;
    logic [BW-1:0] brightness = 2'b11;
    logic [3:0]    digit_val;
    logic [3:0]    digit_sel;
    logic          dp_out, frame_start;

    int checks = 0, errors = 0;

    // reference model state
    int          m_c, m_pwm;
    bit          m_load;
    logic [3:0]  m_dig [D];
    logic [3:0]  m_dp, m_bm;
    logic [3:0]  exp_val, exp_sel;
    logic        exp_dp, exp_fs;

    digit_scan_mux #(.DIGITS(D), .DIV(V), .BRIGHT_W(BW)
`ifdef DIGIT_BLINK_EN
        , .BLINK_FRAMES(BF)
`endif
    ) dut (
        .clk(clk), .rst(rst), .digits_in(digits_in), .dp_in(dp_in),
`ifdef DIGIT_BLINK_EN
        .blink_mask(blink_mask),
`endif
        .lz_blank(lz_blank), .brightness(brightness),
        .digit_val(digit_val), .digit_sel(digit_sel), .dp_out(dp_out), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Advance one clock and recompute what the display should show, from elapsed cycles since load.
    task automatic step();
        int slot, fr;
        bit on, blank;
        @(posedge clk);
        if (rst) begin
            m_load = 1; m_pwm = 0; m_c = 0;
            exp_val = 0; exp_sel = 0; exp_dp = 0; exp_fs = 0;
        end else begin
            on = (brightness == 2'b11) || (m_pwm < int'(brightness));
            m_pwm = (m_pwm + 1) % 4;
            if (m_load) begin m_c = 0; m_load = 0; end
            else m_c++;
            if (m_c % FRAME == 0) begin
                for (int k = 0; k < D; k++) m_dig[k] = digits_in[4*k +: 4];
                m_dp = dp_in;
                m_bm = blink_mask;
            end
            slot = (m_c / V) % D;
            fr   = m_c / FRAME;
            blank = 0;
            if (lz_blank && slot > 0) begin
                blank = 1;
                for (int k = slot; k < D; k++)
                    if (m_dig[k] != 0 || m_dp[k]) blank = 0;
            end
`ifdef DIGIT_BLINK_EN
            if (((fr / BF) % 2) == 1 && m_bm[slot]) blank = 1;
`endif
            exp_val = blank ? 4'hF : m_dig[slot];
            exp_dp  = !blank && m_dp[slot];
            exp_sel = (on && !blank) ? 4'(1 << slot) : 4'h0;
            exp_fs  = (m_c % FRAME == 0);
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1;
        step();
        step();
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({digit_val, digit_sel, dp_out, frame_start} !== 10'h0) begin
                errors++;
                $display("FAIL reset: got val=%h sel=%b dp=%b fs=%b want all zero", digit_val, digit_sel, dp_out, frame_start);
            end
        end
    endtask

    task automatic test_basic_scan();
        digits_in = 16'h1234; dp_in = 0; brightness = 2'b11; lz_blank = 0;
        rst = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            step();
            checks++;
            if ({digit_val, digit_sel, dp_out, frame_start} !== {exp_val, exp_sel, exp_dp, exp_fs}) begin
                errors++;
                $display("FAIL basic_scan cyc %0d: got val=%h sel=%b dp=%b fs=%b want val=%h sel=%b dp=%b fs=%b",
                         i, digit_val, digit_sel, dp_out, frame_start, exp_val, exp_sel, exp_dp, exp_fs);
            end
            if (i == 0) begin
                checks++;
                if ({frame_start, digit_sel, digit_val} !== {1'b1, 4'b0001, 4'h4}) begin
                    errors++;
                    $display("FAIL basic_first: got fs=%b sel=%b val=%h want fs=1 sel=0001 val=4", frame_start, digit_sel, digit_val);
                end
            end
            if (i == 9) begin
                checks++;
                if ({frame_start, digit_sel, digit_val} !== {1'b0, 4'b1000, 4'h1}) begin
                    errors++;
                    $display("FAIL basic_slot3: got fs=%b sel=%b val=%h want fs=0 sel=1000 val=1", frame_start, digit_sel, digit_val);
                end
            end
        end
    endtask

    task automatic test_tear_free();
        do_reset();
        digits_in = 16'h1234;
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (i == 4) digits_in = 16'h5678;
            step();
            checks++;
            if ({digit_val, digit_sel, dp_out, frame_start} !== {exp_val, exp_sel, exp_dp, exp_fs}) begin
                errors++;
                $display("FAIL tear_free cyc %0d: got val=%h sel=%b fs=%b want val=%h sel=%b fs=%b",
                         i, digit_val, digit_sel, frame_start, exp_val, exp_sel, exp_fs);
            end
            if (i == 6 || i == FRAME) begin
                checks++;
                if (digit_val !== ((i == 6) ? 4'h2 : 4'h8)) begin
                    errors++;
                    $display("FAIL tear_free_val cyc %0d: got %h want %h", i, digit_val, (i == 6) ? 4'h2 : 4'h8);
                end
            end
        end
    endtask

    task automatic test_lz_blank();
        logic [15:0] pats [3] = '{16'h0050, 16'h0000, 16'h0050};
        logic [3:0]  dps  [3] = '{4'b0000, 4'b0000, 4'b0100};
        lz_blank = 1;
        for (int p = 0; p < 3; p++) begin
            digits_in = pats[p]; dp_in = dps[p];
            do_reset();
            for (int i = 0; i < FRAME; i++) begin
                step();
                checks++;
                if ({digit_val, digit_sel, dp_out, frame_start} !== {exp_val, exp_sel, exp_dp, exp_fs}) begin
                    errors++;
                    $display("FAIL lz_blank pat %0d cyc %0d: got val=%h sel=%b dp=%b want val=%h sel=%b dp=%b",
                             p, i, digit_val, digit_sel, dp_out, exp_val, exp_sel, exp_dp);
                end
            end
        end
        // last pattern: slot 2 holds a zero kept alive by its decimal point
        do_reset();
        for (int i = 0; i < 7; i++) step();
        checks++;
        if ({digit_val, digit_sel, dp_out} !== {4'h0, 4'b0100, 1'b1}) begin
            errors++;
            $display("FAIL lz_dp: got val=%h sel=%b dp=%b want val=0 sel=0100 dp=1", digit_val, digit_sel, dp_out);
        end
        lz_blank = 0; dp_in = 0;
    endtask

    task automatic test_brightness();
        logic [1:0] lv [3] = '{2'd1, 2'd0, 2'd3};
        int want [3] = '{10, 0, 40};
        int cnt;
        digits_in = 16'h1234;
        do_reset();
        for (int b = 0; b < 3; b++) begin
            brightness = lv[b];
            cnt = 0;
            for (int i = 0; i < 40; i++) begin
                step();
                if (digit_sel != 0) cnt++;
                checks++;
                if ({digit_val, digit_sel, dp_out, frame_start} !== {exp_val, exp_sel, exp_dp, exp_fs}) begin
                    errors++;
                    $display("FAIL brightness %0d cyc %0d: got val=%h sel=%b want val=%h sel=%b",
                             lv[b], i, digit_val, digit_sel, exp_val, exp_sel);
                end
            end
            checks++;
            if (cnt != want[b]) begin
                errors++;
                $display("FAIL brightness_duty %0d: got %0d lit cycles want %0d", lv[b], cnt, want[b]);
            end
        end
        brightness = 2'b11;
    endtask

    task automatic test_mid_reset();
        digits_in = 16'h1234;
        do_reset();
        for (int i = 0; i < 7; i++) step();
        digits_in = 16'hABC9;
        rst = 1;
        step();
        checks++;
        if ({digit_val, digit_sel, dp_out, frame_start} !== 10'h0) begin
            errors++;
            $display("FAIL mid_reset: got val=%h sel=%b dp=%b fs=%b want zeros", digit_val, digit_sel, dp_out, frame_start);
        end
        rst = 0;
        step();
        checks++;
        if ({frame_start, digit_sel, digit_val} !== {1'b1, 4'b0001, 4'h9}) begin
            errors++;
            $display("FAIL mid_reset_restart: got fs=%b sel=%b val=%h want fs=1 sel=0001 val=9", frame_start, digit_sel, digit_val);
        end
    endtask

`ifdef DIGIT_BLINK_EN
    task automatic test_blink();
        digits_in = 16'h1234; blink_mask = 4'b0010; lz_blank = 0; dp_in = 0;
        do_reset();
        for (int i = 0; i < 5 * FRAME; i++) begin
            step();
            checks++;
            if ({digit_val, digit_sel, dp_out, frame_start} !== {exp_val, exp_sel, exp_dp, exp_fs}) begin
                errors++;
                $display("FAIL blink cyc %0d: got val=%h sel=%b want val=%h sel=%b", i, digit_val, digit_sel, exp_val, exp_sel);
            end
            if (i == 3 || i == 2 * FRAME + 3) begin
                checks++;
                if (digit_val !== ((i == 3) ? 4'h3 : 4'hF)) begin
                    errors++;
                    $display("FAIL blink_phase cyc %0d: got %h want %h", i, digit_val, (i == 3) ? 4'h3 : 4'hF);
                end
            end
        end
        blink_mask = 0;
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 9) == 0) digits_in = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom & 32'h00F0);
            if ($urandom_range(0, 9) == 0) dp_in = 4'($urandom);
            if ($urandom_range(0, 15) == 0) lz_blank = ~lz_blank;
            if ($urandom_range(0, 7) == 0) brightness = 2'($urandom);
            if ($urandom_range(0, 7) == 0) blink_mask = 4'($urandom);
            rst = ($urandom_range(0, 99) == 0);
            step();
            checks++;
            if ({digit_val, digit_sel, dp_out, frame_start} !== {exp_val, exp_sel, exp_dp, exp_fs}) begin
                errors++;
                $display("FAIL random cyc %0d: got val=%h sel=%b dp=%b fs=%b want val=%h sel=%b dp=%b fs=%b",
                         i, digit_val, digit_sel, dp_out, frame_start, exp_val, exp_sel, exp_dp, exp_fs);
            end
        end
        rst = 0;
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_tear_free();
        test_lz_blank();
        test_brightness();
        test_mid_reset();
`ifdef DIGIT_BLINK_EN
        test_blink();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
